free_list: RTL

//  Physical-register free list for the rename/dispatch stage, feeding prd values into ROB dispatch.

---
 rtl/free_list_pkg.sv | 11 +
 rtl/free_list_lane_compact.sv | 22 ++
 rtl/free_list.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared constants for the physical-register free list: rename/commit lane count and
// the widths of the per-lane prefix offsets produced by the lane compactor.
package free_list_pkg;

  localparam int LANES = 4;
  localparam int OFF_W = 2;
  localparam int CNT_W = 3;

  typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/free_list_lane_compact.sv
// Turns a 4-lane valid mask into per-lane prefix offsets (set lanes below this one)
// and the total number of set lanes.
module free_list_lane_compact
  import free_list_pkg::*;
(
  input  logic [LANES-1:0]       i_mask,
  output logic [LANES*OFF_W-1:0] o_off,
  output logic [CNT_W-1:0]       o_cnt
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc   = '0;
    o_off = '0;
    for (int i = 0; i < LANES; i++) begin
      o_off[i*OFF_W +: OFF_W] = acc[OFF_W-1:0];
      acc = acc + CNT_W'(i_mask[i]);
    end
    o_cnt = acc;
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: a ring of free prd indices, drained by rename (up to 4/cycle),
// refilled by ROB commit (up to 4/cycle), with branch-tagged head snapshots for kill recovery.
module free_list
  import free_list_pkg::*;
#(
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 4,
  parameter int N_ARCH    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [LANES-1:0]           i_alloc_req,
  output logic [LANES*WIDTH_REG-1:0] o_alloc_prd4x,
  output logic                       o_alloc_rdy,
  input  logic [WIDTH_BRM-1:0]       i_br_save,
  input  logic [WIDTH_BRM:0]         i_kill,
  input  logic                       i_com_en,
  input  logic [LANES-1:0]           i_com_mask,
  input  logic [LANES*WIDTH_REG-1:0] i_com_prd4x,
  output logic [WIDTH_REG:0]         o_count
);

  localparam int NPREG  = 1 << WIDTH_REG;
  localparam int NFREE0 = NPREG - N_ARCH;
  localparam int MEM_W  = NPREG * WIDTH_REG;
  localparam int SNAP_W = WIDTH_BRM * WIDTH_REG;

  function automatic logic [MEM_W-1:0] reset_image();
    logic [MEM_W-1:0] img;
    img = '0;
    for (int e = 0; e < NFREE0; e++) img[e*WIDTH_REG +: WIDTH_REG] = WIDTH_REG'(e + N_ARCH);
    return img;
  endfunction

  localparam logic [MEM_W-1:0] MEM_RST = reset_image();

  logic [MEM_W-1:0]     mem_q, mem_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic [WIDTH_REG-1:0] head_q, head_d;
  logic [WIDTH_REG-1:0] tail_q, tail_d;
  logic [WIDTH_REG:0]   count_q, count_d;

  lane_mask_t             alloc_mask, free_mask;
  logic [LANES*OFF_W-1:0] alloc_off, free_off;
  logic [CNT_W-1:0]       alloc_cnt, free_cnt;
  logic [CNT_W-1:0]       nalloc, nfree;
  logic                   kill_en, grant;
  logic [WIDTH_BRM-1:0]   kill_tag;
  logic [WIDTH_REG-1:0]   snap_sel;

  assign alloc_mask = i_alloc_req;
  assign free_mask  = i_com_mask;
  assign kill_en    = i_kill[WIDTH_BRM];
  assign kill_tag   = i_kill[WIDTH_BRM-1:0];

  free_list_lane_compact u_alloc_compact (
    .i_mask (alloc_mask),
    .o_off  (alloc_off),
    .o_cnt  (alloc_cnt)
  );

  free_list_lane_compact u_free_compact (
    .i_mask (free_mask),
    .o_off  (free_off),
    .o_cnt  (free_cnt)
  );

  assign o_count     = count_q;
  assign o_alloc_rdy = (count_q >= (WIDTH_REG+1)'(LANES));
  assign grant       = (|alloc_mask) && o_alloc_rdy && !kill_en;
  assign nalloc      = grant ? alloc_cnt : '0;
  assign nfree       = i_com_en ? free_cnt : '0;

  // Unrequested lanes read head+lane so an idle port still shows the next four free prds.
  always_comb begin
    logic [WIDTH_REG-1:0] ridx;
    logic [OFF_W-1:0]     off;
    o_alloc_prd4x = '0;
    ridx          = '0;
    off           = '0;
    for (int i = 0; i < LANES; i++) begin
      off  = alloc_mask[i] ? alloc_off[i*OFF_W +: OFF_W] : OFF_W'(i);
      ridx = head_q + WIDTH_REG'(off);
      o_alloc_prd4x[i*WIDTH_REG +: WIDTH_REG] = mem_q[int'(ridx)*WIDTH_REG +: WIDTH_REG];
    end
  end

  // Committed stale prds are packed contiguously at the tail in lane order.
  always_comb begin
    logic [WIDTH_REG-1:0] widx;
    mem_d = mem_q;
    widx  = '0;
    if (i_com_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (free_mask[i]) begin
          widx = tail_q + WIDTH_REG'(free_off[i*OFF_W +: OFF_W]);
          mem_d[int'(widx)*WIDTH_REG +: WIDTH_REG] = i_com_prd4x[i*WIDTH_REG +: WIDTH_REG];
        end
      end
    end
  end

  always_comb begin
    snap_sel = '0;
    for (int b = 0; b < WIDTH_BRM; b++) begin
      if (kill_tag[b]) snap_sel = snap_sel | snap_q[b*WIDTH_REG +: WIDTH_REG];
    end

    tail_d = tail_q + WIDTH_REG'(nfree);

    // On kill the free count is rebuilt from the pointers; free never exceeds NPREG-1.
    if (kill_en) begin
      head_d  = snap_sel;
      count_d = {1'b0, tail_d - snap_sel};
    end else begin
      head_d  = head_q + WIDTH_REG'(nalloc);
      count_d = count_q + (WIDTH_REG+1)'(nfree) - (WIDTH_REG+1)'(nalloc);
    end

    snap_d = snap_q;
    for (int b = 0; b < WIDTH_BRM; b++) begin
      if (i_br_save[b] && !kill_en) snap_d[b*WIDTH_REG +: WIDTH_REG] = head_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q   <= MEM_RST;
      snap_q  <= '0;
      head_q  <= '0;
      tail_q  <= WIDTH_REG'(NFREE0);
      count_q <= (WIDTH_REG+1)'(NFREE0);
    end else begin
      mem_q   <= mem_d;
      snap_q  <= snap_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
